wdog: RTL and testbench

- Software watchdog timer on the system bus.
- Software arms it with a timeout in ticks and kicks it periodically.
- If the kicks stop, it emits a one-cycle trip pulse.
- Trip feeds one bit of the system control block's error-signal input, which latches the error and forces system reset. It sits directly upstream of that block.

---
 rtl/wdog_if.sv | 14 +
 rtl/wdog.sv | 86 ++++++++
 tb/tb_wdog.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/wdog_if.sv
// Register-bus interface for the watchdog: single-cycle strobe, zero-wait-state ack.
interface wdog_if;
  logic        stb;
  logic        we;
  logic        addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (output stb, output we, output addr, output data_in,
                  input  data_out, input ack);
  modport slave  (input  stb, input  we, input  addr, input  data_in,
                  output data_out, output ack);
endinterface

// File: rtl/wdog.sv
// Software watchdog: armed and kicked over the register bus, emits a one-cycle
// trip pulse when the countdown expires without a kick.
module wdog #(
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = 16
) (
  input  logic   clk,
  input  logic   rst,
  wdog_if.slave  bus,
  output logic   trip
);

  localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]  prescaler;
  logic [CNT_W-1:0] timeout;
  logic [CNT_W-1:0] counter;
  logic             enable;
  logic             trip_flag;
  logic             tick;
  logic             ctrl_wr;
  logic             kick_wr;
  logic             rd;
  logic             unused_data;

  assign ctrl_wr = bus.stb & bus.we & ~bus.addr;
  assign kick_wr = bus.stb & bus.we &  bus.addr;
  assign rd      = bus.stb & ~bus.we;
  assign tick    = enable && (prescaler == PS_W'(PRESCALE - 1));

  // Only the timeout field and the two control bits of write data are decoded.
  assign unused_data = &{1'b0, bus.data_in};

  assign bus.ack = bus.stb;

  always_comb begin
    bus.data_out = 32'b0;
    if (rd) begin
      if (bus.addr)
        bus.data_out = {16'b0, 16'(counter)};
      else
        bus.data_out = {16'(timeout), 14'b0, trip_flag, enable};
    end
  end

  // Bus writes take priority over a coincident tick, so a kick landing on a
  // tick cycle suppresses both the decrement and any trip.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable    <= 1'b0;
      trip_flag <= 1'b0;
      timeout   <= '0;
      counter   <= '0;
      prescaler <= '0;
      trip      <= 1'b0;
    end else begin
      trip <= 1'b0;
      if (ctrl_wr) begin
        timeout   <= bus.data_in[16 +: CNT_W];
        counter   <= bus.data_in[16 +: CNT_W];
        enable    <= bus.data_in[0];
        prescaler <= '0;
        if (bus.data_in[1])
          trip_flag <= 1'b0;
      end else if (kick_wr) begin
        counter   <= timeout;
        prescaler <= '0;
      end else if (!enable) begin
        prescaler <= '0;
      end else if (tick) begin
        prescaler <= '0;
        if (counter != '0) begin
          counter <= counter - 1'b1;
        end else begin
          trip      <= 1'b1;
          trip_flag <= 1'b1;
          enable    <= 1'b0;
          counter   <= timeout;
        end
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wdog.sv
// Scoreboard bench for wdog: deadline-based reference model feeds expected
// reads and trip values into queues that a negedge monitor drains.
`timescale 1ns/100ps
module tb_wdog;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst;
  logic trip;

  wdog_if bus();

  wdog #(.PRESCALE(P), .CNT_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .trip (trip)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] read_q[$];
  bit          trip_q[$];

  // Reference model: counter is derived from the cycle of the last reload and
  // the number of whole ticks elapsed since then.
  bit m_en     = 1'b0;
  bit m_flag   = 1'b0;
  int m_tmo    = 0;
  int m_refcnt = 0;
  int m_ref    = 0;
  int cyc      = 0;

  function automatic int m_count();
    return m_en ? (m_refcnt - (cyc - m_ref) / P) : m_refcnt;
  endfunction

  function automatic logic [31:0] m_read(bit a);
    logic [31:0] t;
    t = 32'(m_tmo);
    if (a) return 32'(m_count());
    return {t[15:0], 14'b0, m_flag, m_en};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, got, exp, $time);
    end
  endtask

  // One bus cycle: drive op, let the edge pass, advance the model.
  task automatic op(bit s, bit w, bit a, logic [31:0] d);
    bit tr;
    tr = 1'b0;
    bus.stb = s; bus.we = w; bus.addr = a; bus.data_in = d;
    if (s && !w) read_q.push_back(m_read(a));
    @(posedge clk);
    cyc++;
    if (!rst) begin
      m_en = 0; m_flag = 0; m_tmo = 0; m_refcnt = 0; m_ref = cyc;
    end else if (s && w && !a) begin
      m_tmo = int'(d[31:16]); m_refcnt = m_tmo; m_ref = cyc; m_en = d[0];
      if (d[1]) m_flag = 0;
    end else if (s && w && a) begin
      m_refcnt = m_tmo; m_ref = cyc;
    end else if (m_en && cyc == m_ref + (m_refcnt + 1) * P) begin
      tr = 1'b1; m_flag = 1; m_en = 0; m_refcnt = m_tmo; m_ref = cyc;
    end
    trip_q.push_back(tr);
    #1;
    bus.stb = 1'b0;
  endtask

  task automatic idle();
    op(1'b0, 1'($urandom), 1'($urandom), $urandom);
  endtask

  task automatic rd(bit a);
    op(1'b1, 1'b0, a, $urandom);
  endtask

  always @(negedge clk) begin
    check("ack", 32'(bus.ack), 32'(bus.stb));
    if (bus.stb && !bus.we) begin
      if (read_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL read_q: got read with no expectation queued at %0t", $time);
      end else begin
        check(bus.addr ? "count_read" : "ctrl_read", bus.data_out, read_q.pop_front());
      end
    end else begin
      check("idle_dout", bus.data_out, 32'h0);
    end
    if (trip_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL trip_q: got cycle with no expectation queued at %0t", $time);
    end else begin
      check("trip", 32'(trip), 32'(trip_q.pop_front()));
    end
  end

  initial begin
    bus.stb = 1'b0; bus.we = 1'b0; bus.addr = 1'b0; bus.data_in = '0;
    rst = 1'b0;
    repeat (3) idle();
    rd(1'b0);
    rd(1'b1);
    rst = 1'b1;
    repeat (2) idle();

    // Arm with no kicks: trip 16 cycles after the write, then inspect.
    op(1'b1, 1'b1, 1'b0, 32'h0003_0001);
    repeat (20) idle();
    rd(1'b0);
    rd(1'b1);

    // Kick service every 8 cycles; counter must never run out.
    op(1'b1, 1'b1, 1'b0, 32'h0002_0001);
    repeat (12) begin
      op(1'b1, 1'b1, 1'b1, $urandom);
      repeat (3) idle();
      rd(1'b1);
      repeat (3) idle();
    end
    op(1'b1, 1'b1, 1'b0, 32'h0002_0002);
    repeat (4) idle();

    // Zero timeout, then a kick landing exactly on a tick.
    op(1'b1, 1'b1, 1'b0, 32'h0000_0001);
    repeat (6) idle();
    op(1'b1, 1'b1, 1'b0, 32'h0001_0001);
    repeat (3) idle();
    op(1'b1, 1'b1, 1'b1, $urandom);
    repeat (10) idle();
    rd(1'b0);

    // Clear flag without arming, then re-arm.
    op(1'b1, 1'b1, 1'b0, 32'h0005_0002);
    rd(1'b0);
    rd(1'b1);
    repeat (100) idle();
    op(1'b1, 1'b1, 1'b0, 32'h0005_0001);
    repeat (26) idle();
    rd(1'b0);

    // Asynchronous reset pulse in the middle of a long countdown.
    op(1'b1, 1'b1, 1'b0, 32'h00FF_0001);
    repeat (509) idle();
    rd(1'b1);
    #1;
    bus.stb = 1'b1; bus.we = 1'b0; bus.addr = 1'b0;
    rst = 1'b0;
    #0.2;
    check("rst_trip", 32'(trip), 32'h0);
    check("rst_ctrl", bus.data_out, 32'h0);
    bus.addr = 1'b1;
    #0.2;
    check("rst_count", bus.data_out, 32'h0);
    rst = 1'b1;
    #0.2;
    bus.stb = 1'b0;
    m_en = 0; m_flag = 0; m_tmo = 0; m_refcnt = 0; m_ref = cyc;
    repeat (100) idle();
    rd(1'b0);
    rd(1'b1);

    // Random traffic: short timeouts so trips, kicks and collisions all occur.
    repeat (1500) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3)
        op(1'b1, 1'b1, 1'b0, {16'($urandom_range(0, 5)), 14'($urandom),
                              1'($urandom), ($urandom_range(0, 3) != 0)});
      else if (r < 12)
        op(1'b1, 1'b1, 1'b1, $urandom);
      else if (r < 37)
        rd(1'($urandom));
      else
        idle();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
